// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin grant of one functional-unit result per cycle onto
// the common data bus, with a registered broadcast that holds under ROB
// back-pressure and is killed by a branch flush.
module cdb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*TAG_W-1:0] req_tag,
  input  logic [NUM_REQ*32-1:0]    req_data,
  output logic [NUM_REQ-1:0]       gnt,
  input  logic                     cdb_stall,
  input  logic                     flush,
  output logic                     cdb_valid,
  output logic [TAG_W-1:0]         cdb_tag,
  output logic [31:0]              cdb_data
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] win;
  logic [PTR_W:0]   idx_w;
  logic             any_req;
  logic             accept;
  logic             grant;
  logic [TAG_W-1:0] win_tag;
  logic [31:0]      win_data;

  logic             cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0] cdb_tag_q, cdb_tag_d;
  logic [31:0]      cdb_data_q, cdb_data_d;

  // A new result can be taken when the bus is free or being consumed this
  // cycle; flush and reset both suppress granting.
  assign accept = (!cdb_valid_q || !cdb_stall) && !flush && rst;
  assign grant  = accept && any_req;

  // Find the first pending requester scanning upward from ptr, wrapping.
  always_comb begin
    win     = '0;
    any_req = 1'b0;
    idx_w   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_w = {1'b0, ptr_q} + (PTR_W+1)'(k);
      if (idx_w >= (PTR_W+1)'(NUM_REQ)) idx_w = idx_w - (PTR_W+1)'(NUM_REQ);
      if (!any_req && req[idx_w[PTR_W-1:0]]) begin
        any_req = 1'b1;
        win     = idx_w[PTR_W-1:0];
      end
    end
  end

  // One-hot grant plus an AND-OR mux of the winner's payload; the payload
  // never feeds back into the grant decision.
  always_comb begin
    gnt      = '0;
    win_tag  = '0;
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt[i] = grant && (win == PTR_W'(i));
      if (gnt[i]) begin
        win_tag  = req_tag[i*TAG_W +: TAG_W];
        win_data = req_data[i*32 +: 32];
      end
    end
  end

  // Next pointer and broadcast register contents, flush taking priority.
  always_comb begin
    ptr_d       = ptr_q;
    cdb_valid_d = 1'b0;
    cdb_tag_d   = cdb_tag_q;
    cdb_data_d  = cdb_data_q;
    if (grant) begin
      if (win == PTR_W'(NUM_REQ-1)) ptr_d = '0;
      else                          ptr_d = win + PTR_W'(1);
    end
    if (flush) begin
      cdb_valid_d = 1'b0;
    end else if (grant) begin
      cdb_valid_d = 1'b1;
      cdb_tag_d   = win_tag;
      cdb_data_d  = win_data;
    end else if (cdb_valid_q && cdb_stall) begin
      cdb_valid_d = 1'b1;
    end
  end

  // State registers; reset discards any broadcast held under stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q       <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_data  = cdb_data_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter (NUM_REQ=4, TAG_W=3).
module tb_cdb_arbiter;
  logic         clk;
  logic         rst;
  logic [3:0]   req;
  logic [11:0]  req_tag;
  logic [127:0] req_data;
  logic [3:0]   gnt;
  logic         cdb_stall;
  logic         flush;
  logic         cdb_valid;
  logic [2:0]   cdb_tag;
  logic [31:0]  cdb_data;

  int n_checks = 0;
  int n_fail   = 0;

  cdb_arbiter #(.NUM_REQ(4), .TAG_W(3)) dut (
    .clk(clk), .rst(rst), .req(req), .req_tag(req_tag), .req_data(req_data),
    .gnt(gnt), .cdb_stall(cdb_stall), .flush(flush),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int i, input logic [2:0] t, input logic [31:0] d);
    req_tag[i*3 +: 3]   = t;
    req_data[i*32 +: 32] = d;
  endtask

  task automatic test_reset();
    req = 4'b0001;
    #1;
    n_checks++; if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", cdb_valid); end
    n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt_forced got %b exp 0000", gnt); end
    n_checks++; if (dut.ptr_q !== 2'd0) begin n_fail++; $display("FAIL reset_ptr got %0d exp 0", dut.ptr_q); end
    req = 4'b0000;
    step();
    #3 rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      n_checks++; if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid c%0d got %b exp 0", c, cdb_valid); end
      n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL idle_gnt c%0d got %b exp 0000", c, gnt); end
      n_checks++; if (dut.ptr_q !== 2'd0) begin n_fail++; $display("FAIL idle_ptr c%0d got %0d exp 0", c, dut.ptr_q); end
    end
  endtask

  task automatic test_single();
    set_slot(2, 3'd5, 32'hDEADBEEF);
    req = 4'b0100;
    #1;
    n_checks++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL single_gnt got %b exp 0100", gnt); end
    step();
    req = 4'b0000;
    n_checks++; if (cdb_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b exp 1", cdb_valid); end
    n_checks++; if (cdb_tag !== 3'd5) begin n_fail++; $display("FAIL single_tag got %0d exp 5", cdb_tag); end
    n_checks++; if (cdb_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_data got %h exp deadbeef", cdb_data); end
    n_checks++; if (dut.ptr_q !== 2'd3) begin n_fail++; $display("FAIL single_ptr got %0d exp 3", dut.ptr_q); end
    step();
    n_checks++; if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL single_drop got %b exp 0", cdb_valid); end
  endtask

  task automatic test_fairness();
    logic [3:0] exp_g;
    // Restart from ptr=0 with a reset pulse between edges.
    rst = 1'b0;
    #2 rst = 1'b1;
    for (int i = 0; i < 4; i++) set_slot(i, 3'(i), 32'hA000_0000 + 32'(i));
    req = 4'b1111;
    #1;
    for (int c = 0; c < 8; c++) begin
      exp_g = 4'b0001 << (c % 4);
      n_checks++; if (gnt !== exp_g) begin n_fail++; $display("FAIL fair_gnt c%0d got %b exp %b", c, gnt, exp_g); end
      step();
      n_checks++; if (cdb_valid !== 1'b1 || cdb_tag !== 3'(c % 4) || cdb_data !== 32'hA000_0000 + 32'(c % 4))
        begin n_fail++; $display("FAIL fair_bcast c%0d got v%b t%0d d%h exp v1 t%0d", c, cdb_valid, cdb_tag, cdb_data, c % 4); end
    end
    req = 4'b0000;
    step();
    n_checks++; if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL fair_idle got %b exp 0", cdb_valid); end
  endtask

  task automatic test_stall();
    set_slot(0, 3'd1, 32'h0000_0111);
    set_slot(1, 3'd2, 32'h0000_0222);
    req = 4'b0011;
    #1;
    n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL stall_first_gnt got %b exp 0001", gnt); end
    step();
    req = 4'b0010;
    cdb_stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL stall_gnt c%0d got %b exp 0000", c, gnt); end
      n_checks++; if (cdb_valid !== 1'b1 || cdb_tag !== 3'd1 || cdb_data !== 32'h111)
        begin n_fail++; $display("FAIL stall_hold c%0d got v%b t%0d d%h exp v1 t1 d111", c, cdb_valid, cdb_tag, cdb_data); end
      step();
    end
    cdb_stall = 1'b0;
    #1;
    n_checks++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL stall_release_gnt got %b exp 0010", gnt); end
    step();
    req = 4'b0000;
    n_checks++; if (cdb_valid !== 1'b1 || cdb_tag !== 3'd2 || cdb_data !== 32'h222)
      begin n_fail++; $display("FAIL stall_next got v%b t%0d d%h exp v1 t2 d222", cdb_valid, cdb_tag, cdb_data); end
    step();
    n_checks++; if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL stall_idle got %b exp 0", cdb_valid); end
  endtask

  task automatic test_flush();
    // ptr is 2 here.
    set_slot(2, 3'd6, 32'h0000_000C);
    set_slot(3, 3'd3, 32'h0000_0333);
    req = 4'b0100;
    #1;
    n_checks++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL flush_pre_gnt got %b exp 0100", gnt); end
    step();
    req = 4'b0000;
    cdb_stall = 1'b1;
    step();
    n_checks++; if (cdb_valid !== 1'b1 || cdb_tag !== 3'd6) begin n_fail++; $display("FAIL flush_held got v%b t%0d exp v1 t6", cdb_valid, cdb_tag); end
    flush = 1'b1;
    req = 4'b1000;
    #1;
    n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL flush_gnt got %b exp 0000", gnt); end
    step();
    flush = 1'b0;
    req = 4'b0000;
    cdb_stall = 1'b0;
    n_checks++; if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %b exp 0", cdb_valid); end
    n_checks++; if (dut.ptr_q !== 2'd3) begin n_fail++; $display("FAIL flush_ptr got %0d exp 3", dut.ptr_q); end
  endtask

  task automatic test_back_to_back();
    // ptr is 3: only requester 0 pending wins twice in a row.
    set_slot(0, 3'd4, 32'h0000_0001);
    req = 4'b0001;
    #1;
    n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL b2b_gnt0 got %b exp 0001", gnt); end
    step();
    set_slot(0, 3'd4, 32'h0000_0002);
    n_checks++; if (cdb_valid !== 1'b1 || cdb_data !== 32'h1) begin n_fail++; $display("FAIL b2b_first got v%b d%h exp v1 d1", cdb_valid, cdb_data); end
    #1;
    n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL b2b_gnt1 got %b exp 0001", gnt); end
    step();
    req = 4'b0000;
    n_checks++; if (cdb_valid !== 1'b1 || cdb_data !== 32'h2) begin n_fail++; $display("FAIL b2b_second got v%b d%h exp v1 d2", cdb_valid, cdb_data); end
    step();
  endtask

  task automatic test_async_reset();
    // ptr is 1: requester 3 alone still wins.
    set_slot(3, 3'd7, 32'hFFFF_0000);
    req = 4'b1000;
    #1;
    n_checks++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL areset_pre_gnt got %b exp 1000", gnt); end
    step();
    req = 4'b0000;
    cdb_stall = 1'b1;
    n_checks++; if (cdb_valid !== 1'b1 || cdb_tag !== 3'd7) begin n_fail++; $display("FAIL areset_held got v%b t%0d exp v1 t7", cdb_valid, cdb_tag); end
    #2 rst = 1'b0;
    req = 4'b0001;
    #1;
    n_checks++; if (cdb_valid !== 1'b0 || cdb_tag !== 3'd0 || cdb_data !== 32'h0)
      begin n_fail++; $display("FAIL areset_clear got v%b t%0d d%h exp all 0", cdb_valid, cdb_tag, cdb_data); end
    n_checks++; if (dut.ptr_q !== 2'd0) begin n_fail++; $display("FAIL areset_ptr got %0d exp 0", dut.ptr_q); end
    n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL areset_gnt got %b exp 0000", gnt); end
    #1 rst = 1'b1;
    cdb_stall = 1'b0;
    #1;
    n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL areset_first_gnt got %b exp 0001", gnt); end
    step();
    req = 4'b0000;
    n_checks++; if (cdb_valid !== 1'b1 || cdb_tag !== 3'd4 || cdb_data !== 32'h2)
      begin n_fail++; $display("FAIL areset_bcast got v%b t%0d d%h exp v1 t4 d2", cdb_valid, cdb_tag, cdb_data); end
    step();
    n_checks++; if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL areset_idle got %b exp 0", cdb_valid); end
  endtask

  initial begin
    rst       = 1'b0;
    req       = '0;
    req_tag   = '0;
    req_data  = '0;
    cdb_stall = 1'b0;
    flush     = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_stall();
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
